// File: rtl/timer_scheduler.sv
// Shares one prescaled countdown between four requesters: arm, driver, passenger, alarm-on.
// Latency: grant 1 cycle after the request edge, load 1 cycle later, expiry D*TICK_DIV+1 cycles after load.
// Backpressure: requests queue in a pending register; option macro TIMER_SCHED_PREEMPT_EN lets higher priority preempt.
module timer_scheduler #(
    parameter int TW       = 4,
    parameter int TICK_DIV = 50000000,
    parameter int DLY0     = 6,
    parameter int DLY1     = 8,
    parameter int DLY2     = 15,
    parameter int DLY3     = 10
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [3:0]    i_req,
    input  logic [3:0]    i_cancel,
    input  logic          i_prog_we,
    input  logic [1:0]    i_prog_sel,
    input  logic [TW-1:0] i_prog_val,
    output logic [3:0]    o_grant,
    output logic [3:0]    o_expired,
    output logic          o_busy,
    output logic [TW-1:0] o_remaining,
    output logic          o_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [3:0]    r_pending;
    logic [3:0]    r_grant;
    logic [1:0]    r_owner;
    logic [3:0]    r_expired;
    logic          r_busy;
    logic [TW-1:0] r_remaining;
    logic          r_tick;
    logic [PW-1:0] r_prescale;
    logic [TW-1:0] r_table [4];

    logic [1:0]    w_pick_idx;
    logic          w_own_cancel;
    logic          w_retrig;
    logic          w_preempt;
    logic [3:0]    w_pend_next;

    // Highest set pending bit wins (alarm-on over passenger over driver over arm)
    always_comb begin
        w_pick_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_pending[i]) begin
                w_pick_idx = 2'(i);
            end
        end
    end

    // Owner-directed controls only matter while the countdown resource is held
    assign w_own_cancel = ((r_state == S_LOAD) || (r_state == S_RUN)) && i_cancel[r_owner];
    assign w_retrig     = (r_state == S_RUN) && i_req[r_owner];

`ifdef TIMER_SCHED_PREEMPT_EN
    logic [3:0] w_higher;

    // Mask of requesters that outrank the current owner
    always_comb begin
        w_higher = 4'd0;
        for (int i = 0; i < 4; i++) begin
            w_higher[i] = (2'(i) > r_owner);
        end
    end

    assign w_preempt = (r_state == S_RUN) && !w_own_cancel && !w_retrig &&
                       ((r_pending & w_higher) != 4'd0);
`else
    assign w_preempt = 1'b0;
`endif

    // Next pending set: drop the bit being granted, add new requests (owner's own req is a retrigger), cancel wins
    always_comb begin
        w_pend_next = r_pending;
        if ((r_state == S_IDLE) && (r_pending != 4'd0)) begin
            w_pend_next[w_pick_idx] = 1'b0;
        end
        if (r_state == S_RUN) begin
            w_pend_next = w_pend_next | (i_req & ~r_grant);
        end else begin
            w_pend_next = w_pend_next | i_req;
        end
        if (w_preempt) begin
            w_pend_next = w_pend_next | r_grant;
        end
        w_pend_next = w_pend_next & ~i_cancel;
    end

    // Pending request register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pending <= 4'd0;
        end else begin
            r_pending <= w_pend_next;
        end
    end

    // Delay table; a write only affects the next load, never a countdown in progress
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_table[0] <= TW'(DLY0);
            r_table[1] <= TW'(DLY1);
            r_table[2] <= TW'(DLY2);
            r_table[3] <= TW'(DLY3);
        end else if (i_prog_we) begin
            r_table[i_prog_sel] <= i_prog_val;
        end
    end

    // Grant / load / countdown / expiry sequencer with registered outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_grant     <= 4'd0;
            r_owner     <= 2'd0;
            r_expired   <= 4'd0;
            r_busy      <= 1'b0;
            r_remaining <= '0;
            r_tick      <= 1'b0;
            r_prescale  <= '0;
        end else begin
            r_tick    <= 1'b0;
            r_expired <= 4'd0;
            case (r_state)
                S_IDLE: begin
                    if (r_pending != 4'd0) begin
                        r_owner <= w_pick_idx;
                        r_grant <= 4'b0001 << w_pick_idx;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_own_cancel) begin
                        r_state     <= S_IDLE;
                        r_grant     <= 4'd0;
                        r_busy      <= 1'b0;
                        r_remaining <= '0;
                        r_prescale  <= '0;
                    end else begin
                        r_remaining <= r_table[r_owner];
                        r_prescale  <= '0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_own_cancel || w_preempt) begin
                        // Abort without an expiry pulse; a preempted owner was requeued above
                        r_state     <= S_IDLE;
                        r_grant     <= 4'd0;
                        r_busy      <= 1'b0;
                        r_remaining <= '0;
                        r_prescale  <= '0;
                    end else if (w_retrig) begin
                        r_remaining <= r_table[r_owner];
                        r_prescale  <= '0;
                    end else if (r_remaining == '0) begin
                        r_expired <= r_grant;
                        r_state   <= S_DONE;
                    end else if (r_prescale == PRE_LAST) begin
                        // Nonzero here, so the decrement cannot wrap
                        r_prescale  <= '0;
                        r_remaining <= r_remaining - TW'(1);
                        r_tick      <= 1'b1;
                    end else begin
                        r_prescale <= r_prescale + PW'(1);
                    end
                end
                S_DONE: begin
                    r_grant <= 4'd0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_expired   = r_expired;
    assign o_busy      = r_busy;
    assign o_remaining = r_remaining;
    assign o_tick      = r_tick;

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: event-time model of the shared countdown plus literal cycle checks.
// Latency: model expectations are aligned to the edge that samples each input.
// Backpressure: none; requests are single-cycle pulses.
module tb_timer_scheduler;

    localparam int TD = 5;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'd0;
    logic [3:0] cancel = 4'd0;
    logic       pwe = 1'b0;
    logic [1:0] psel = 2'd0;
    logic [3:0] pval = 4'd0;
    logic [3:0] o_grant;
    logic [3:0] o_expired;
    logic       o_busy;
    logic [3:0] o_remaining;
    logic       o_tick;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;

    // Model state: countdown is D ticks started at a load edge, el run edges since then
    int       m_ph = P_IDLE;
    int       m_own = 0;
    int       m_D = 0;
    int       m_el = 0;
    bit [3:0] m_pend = 4'd0;
    int       m_tbl [4] = '{6, 8, 15, 10};
    logic [3:0] e_grant = 4'd0;
    logic [3:0] e_exp = 4'd0;
    logic       e_busy = 1'b0;
    logic       e_tick = 1'b0;

    always #5 clk = ~clk;

    timer_scheduler #(
        .TW(4), .TICK_DIV(TD), .DLY0(6), .DLY1(8), .DLY2(15), .DLY3(10)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_req(req),
        .i_cancel(cancel),
        .i_prog_we(pwe),
        .i_prog_sel(psel),
        .i_prog_val(pval),
        .o_grant(o_grant),
        .o_expired(o_expired),
        .o_busy(o_busy),
        .o_remaining(o_remaining),
        .o_tick(o_tick)
    );

    function automatic int top_bit(bit [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int cur_rem();
        int r = m_D - (m_el / TD);
        return (r < 0) ? 0 : r;
    endfunction

    // Behavioural model, one step per clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = P_IDLE; m_own = 0; m_D = 0; m_el = 0; m_pend = 4'd0;
            m_tbl = '{6, 8, 15, 10};
            e_grant = 4'd0; e_exp = 4'd0; e_busy = 1'b0; e_tick = 1'b0;
        end else begin
            bit [3:0] np;
            int ph0, own0, hi;
            bit abort;
            np = m_pend; ph0 = m_ph; own0 = m_own; abort = 1'b0;
            e_tick = 1'b0; e_exp = 4'd0;
            case (m_ph)
                P_IDLE: if (m_pend != 4'd0) begin
                    hi = top_bit(m_pend);
                    np[hi] = 1'b0; m_own = hi; m_ph = P_LOAD;
                    e_grant = 4'd0; e_grant[hi] = 1'b1; e_busy = 1'b1;
                end
                P_LOAD: if (cancel[m_own]) abort = 1'b1;
                        else begin m_D = m_tbl[m_own]; m_el = 0; m_ph = P_RUN; end
                P_RUN: begin
                    if (cancel[m_own]) abort = 1'b1;
                    else if (req[m_own]) begin m_D = m_tbl[m_own]; m_el = 0; end
`ifdef TIMER_SCHED_PREEMPT_EN
                    else if (top_bit(m_pend) > m_own) begin np[m_own] = 1'b1; abort = 1'b1; end
`endif
                    else if (cur_rem() == 0) begin m_ph = P_DONE; e_exp = e_grant; end
                    else begin
                        m_el++;
                        if (m_el % TD == 0) e_tick = 1'b1;
                    end
                end
                default: begin m_ph = P_IDLE; e_grant = 4'd0; e_busy = 1'b0; end
            endcase
            if (abort) begin
                m_ph = P_IDLE; e_grant = 4'd0; e_busy = 1'b0; m_D = 0; m_el = 0;
            end
            for (int i = 0; i < 4; i++)
                if (req[i] && !(ph0 == P_RUN && i == own0)) np[i] = 1'b1;
            m_pend = np & ~cancel;
            if (pwe) m_tbl[psel] = int'(pval);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", nm, got, exp, t, $time);
        end
    endtask

    task automatic cmp_model();
        chk("model grant", 32'(o_grant), 32'(e_grant));
        chk("model expired", 32'(o_expired), 32'(e_exp));
        chk("model busy", 32'(o_busy), 32'(e_busy));
        chk("model remaining", 32'(o_remaining), 32'(cur_rem()));
        chk("model tick", 32'(o_tick), 32'(e_tick));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cmp_model();
        t++;
    endtask

    task automatic adv_to(input int k);
        while (t < k) step();
    endtask

    // Inputs are held for exactly one sampling edge; t is then the cycle after that edge
    task automatic pulse(input logic [3:0] r, input logic [3:0] c,
                         input logic we, input logic [1:0] sel, input logic [3:0] val);
        req = r; cancel = c; pwe = we; psel = sel; pval = val;
        @(posedge clk);
        #1;
        req = 4'd0; cancel = 4'd0; pwe = 1'b0; psel = 2'd0; pval = 4'd0;
        cmp_model();
        t++;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #10;
        chk("reset grant", 32'(o_grant), 0);
        chk("reset busy", 32'(o_busy), 0);
        chk("reset remaining", 32'(o_remaining), 0);
        chk("reset expired", 32'(o_expired), 0);
        chk("reset tick", 32'(o_tick), 0);
        #10 rst_n = 1'b1;
        step(); step();

        // Default table, driver delay 8
        pulse(4'b0010, 4'd0, 1'b0, 2'd0, 4'd0); t = 0;
        adv_to(1);  chk("t1 grant", 32'(o_grant), 32'h2);
        adv_to(2);  chk("t1 rem load", 32'(o_remaining), 8);
        adv_to(7);  chk("t1 first tick rem", 32'(o_remaining), 7);
                    chk("t1 first tick", 32'(o_tick), 1);
        adv_to(42); chk("t1 exp early", 32'(o_expired), 0);
        adv_to(43); chk("t1 exp", 32'(o_expired), 32'h2);
        adv_to(44); chk("t1 grant clear", 32'(o_grant), 0);
        adv_to(46);

        // Arbitration: passenger first, arm after one IDLE cycle
        pulse(4'b0101, 4'd0, 1'b0, 2'd0, 4'd0); t = 0;
        adv_to(1);   chk("arb grant2", 32'(o_grant), 32'h4);
        adv_to(78);  chk("arb exp2", 32'(o_expired), 32'h4);
        adv_to(79);  chk("arb idle gap", 32'(o_grant), 0);
        adv_to(80);  chk("arb grant0", 32'(o_grant), 32'h1);
        adv_to(81);  chk("arb rem0", 32'(o_remaining), 6);
        adv_to(112); chk("arb exp0", 32'(o_expired), 32'h1);
        adv_to(114);

        // Reprogram during a countdown
        pulse(4'b0010, 4'd0, 1'b0, 2'd0, 4'd0); t = 0;
        adv_to(10);
        pulse(4'd0, 4'd0, 1'b1, 2'd3, 4'd2);
        adv_to(43); chk("prog owner1 unaffected", 32'(o_expired), 32'h2);
        adv_to(45);
        pulse(4'b1000, 4'd0, 1'b0, 2'd0, 4'd0); t = 0;
        adv_to(12); chk("prog d2 early", 32'(o_expired), 0);
        adv_to(13); chk("prog d2 exp", 32'(o_expired), 32'h8);
        adv_to(15);
        pulse(4'd0, 4'd0, 1'b1, 2'd3, 4'd0);
        pulse(4'b1000, 4'd0, 1'b0, 2'd0, 4'd0); t = 0;
        adv_to(2); chk("d0 rem", 32'(o_remaining), 0);
        adv_to(3); chk("d0 exp", 32'(o_expired), 32'h8);
        adv_to(4); chk("d0 grant clear", 32'(o_grant), 0);
        adv_to(6);

        // Cancel at remaining 5
        pulse(4'b0100, 4'd0, 1'b0, 2'd0, 4'd0); t = 0;
        adv_to(53); chk("cancel pre rem", 32'(o_remaining), 5);
        pulse(4'd0, 4'b0100, 1'b0, 2'd0, 4'd0);
        chk("cancel grant", 32'(o_grant), 0);
        chk("cancel rem", 32'(o_remaining), 0);
        step(); chk("cancel no exp", 32'(o_expired), 0);

        // Retrigger at remaining 3
        pulse(4'b0100, 4'd0, 1'b0, 2'd0, 4'd0); t = 0;
        adv_to(63); chk("retrig pre rem", 32'(o_remaining), 3);
        pulse(4'b0100, 4'd0, 1'b0, 2'd0, 4'd0);
        chk("retrig rem", 32'(o_remaining), 15);
        chk("retrig grant", 32'(o_grant), 32'h4);
        adv_to(70);
        pulse(4'd0, 4'b0100, 1'b0, 2'd0, 4'd0);
        step();

        // Request and cancel together leave nothing pending
        pulse(4'b0001, 4'b0001, 1'b0, 2'd0, 4'd0); t = 0;
        adv_to(2); chk("req+cancel grant", 32'(o_grant), 0);
                   chk("req+cancel busy", 32'(o_busy), 0);

        // Async reset mid-run with a queued request
        pulse(4'b0010, 4'd0, 1'b0, 2'd0, 4'd0); t = 0;
        adv_to(10);
        pulse(4'b0001, 4'd0, 1'b0, 2'd0, 4'd0);
        adv_to(12);
        #2 rst_n = 1'b0;
        #1;
        chk("arst grant", 32'(o_grant), 0);
        chk("arst busy", 32'(o_busy), 0);
        chk("arst rem", 32'(o_remaining), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        step(); step(); step();
        chk("arst pending cleared", 32'(o_grant), 0);
        pulse(4'b1000, 4'd0, 1'b0, 2'd0, 4'd0); t = 0;
        adv_to(52); chk("arst tbl3 early", 32'(o_expired), 0);
        adv_to(53); chk("arst tbl3 exp", 32'(o_expired), 32'h8);
        adv_to(55);
        pulse(4'b0001, 4'd0, 1'b0, 2'd0, 4'd0); t = 0;
        adv_to(33); chk("arst tbl0 exp", 32'(o_expired), 32'h1);
        adv_to(35);

        // Higher-priority request while arm delay runs
        pulse(4'b0001, 4'd0, 1'b0, 2'd0, 4'd0); t = 0;
        adv_to(10);
        pulse(4'b1000, 4'd0, 1'b0, 2'd0, 4'd0); t = 0;
`ifdef TIMER_SCHED_PREEMPT_EN
        adv_to(1);  chk("pre idle", 32'(o_grant), 0);
        adv_to(2);  chk("pre grant3", 32'(o_grant), 32'h8);
        adv_to(54); chk("pre exp3", 32'(o_expired), 32'h8);
        adv_to(56); chk("pre regrant0", 32'(o_grant), 32'h1);
        adv_to(57); chk("pre restart rem", 32'(o_remaining), 6);
        adv_to(88); chk("pre exp0", 32'(o_expired), 32'h1);
        adv_to(90);
`else
        adv_to(22); chk("nopre exp0", 32'(o_expired), 32'h1);
        adv_to(23); chk("nopre idle", 32'(o_grant), 0);
        adv_to(24); chk("nopre grant3", 32'(o_grant), 32'h8);
        adv_to(76); chk("nopre exp3", 32'(o_expired), 32'h8);
        adv_to(78);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
